// File: rtl/vga_char_write_queue.sv
// ---------------------------------------------------------------------------
// vga_char_write_queue
//
// Purpose:
//   This block decouples an upstream character writer from the VGA character
//   buffer. Each write accepted on the Avalon slave port is stored as an
//   {address, data} pair in a small FIFO. The pairs are replayed on the
//   Avalon master port in the same order, one per cycle. The master port
//   honours the buffer's waitrequest. The slave port supports writes only.
//   A read attempt returns 0 and sets a sticky error flag.
//
// Ports:
//   clk            in   single clock for all state
//   reset_n        in   asynchronous active-low reset
//   s_address      in   ADDR_W  character buffer address from the writer
//   s_write        in   1       slave write request
//   s_writedata    in   DATA_W  slave write data (character code in [7:0])
//   s_read         in   1       slave read request (not supported)
//   s_readdata     out  DATA_W  always 0
//   s_waitrequest  out  1       stall to the writer (FIFO full and writing)
//   m_address      out  ADDR_W  head entry address, 0 when the FIFO is empty
//   m_write        out  1       high whenever the FIFO holds an entry
//   m_writedata    out  DATA_W  head entry data, 0 when the FIFO is empty
//   m_read         out  1       tied 0
//   m_waitrequest  in   1       stall from the character buffer
//   level          out  $clog2(DEPTH)+1  occupied entry count
//   err_read       out  1       sticky flag, set by any slave read attempt
// ---------------------------------------------------------------------------
module vga_char_write_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic [ADDR_W-1:0]          s_address,
    input  logic                       s_write,
    input  logic [DATA_W-1:0]          s_writedata,
    input  logic                       s_read,
    output logic [DATA_W-1:0]          s_readdata,
    output logic                       s_waitrequest,

    output logic [ADDR_W-1:0]          m_address,
    output logic                       m_write,
    output logic [DATA_W-1:0]          m_writedata,
    output logic                       m_read,
    input  logic                       m_waitrequest,

    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_read
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              err_flag;

    logic              full;
    logic              not_empty;
    logic              push;
    logic              pop;

    // The full test uses the registered count only. A pop in the same cycle
    // does not free a slot for the writer until the following cycle. This
    // keeps s_waitrequest off any path from m_waitrequest.
    assign full      = (count == FULL_COUNT);
    assign not_empty = (count != '0);

    assign s_waitrequest = full & s_write;
    assign push          = s_write & ~full;
    assign pop           = not_empty & ~m_waitrequest;

    // The master side is show-ahead: the head entry is presented as soon as
    // it is stored. The address and data are gated to 0 while the FIFO is
    // empty, so stale array contents never reach the bus.
    assign m_write     = not_empty;
    assign m_address   = not_empty ? addr_mem[rd_ptr] : '0;
    assign m_writedata = not_empty ? data_mem[rd_ptr] : '0;
    assign m_read      = 1'b0;

    assign s_readdata = '0;
    assign level      = count;
    assign err_read   = err_flag;

    // Pointers are exactly log2(DEPTH) bits wide. Because DEPTH is a power
    // of two, the natural binary overflow gives the modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            err_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_read) begin
                err_flag <= 1'b1;
            end
        end
    end

    // The storage array has no reset. Its contents are invisible while
    // count is 0, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= s_address;
            data_mem[wr_ptr] <= s_writedata;
        end
    end

endmodule

// File: tb/tb_vga_char_write_queue.sv
// ---------------------------------------------------------------------------
// tb_vga_char_write_queue
//
// Purpose:
//   Directed self-checking bench for vga_char_write_queue with DEPTH = 4.
//   Each stimulus cycle drives the inputs on the falling edge. It compares
//   every output against a small queue model of the specified behaviour, and
//   then advances the model on the rising edge. Hand-computed checks of
//   level, head values and err_read are added at the key points of each
//   scenario.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_vga_char_write_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] s_address;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic              s_read;
    logic [DATA_W-1:0] s_readdata;
    logic              s_waitrequest;
    logic [ADDR_W-1:0] m_address;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic              m_read;
    logic              m_waitrequest;
    logic [LVL_W-1:0]  level;
    logic              err_read;

    int     num_compared;
    int     num_mismatched;
    entry_t model_q[$];
    logic   model_err;

    vga_char_write_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_waitrequest (m_waitrequest),
        .level         (level),
        .err_read      (err_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Starts and ends on a falling edge. It drives one cycle of inputs, checks
    // all outputs against the model, and then steps the model on the rising
    // edge. accepted reports whether the model took the push.
    task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input logic rd,
                                 input logic mwait, output logic accepted);
        logic exp_full;
        logic exp_pop;
        logic exp_push;
        s_write       = wr;
        s_address     = addr;
        s_writedata   = data;
        s_read        = rd;
        m_waitrequest = mwait;
        #1;
        exp_full = (model_q.size() == DEPTH);
        checkOutput("s_waitrequest", 64'(s_waitrequest), 64'(exp_full & wr));
        checkOutput("m_write", 64'(m_write), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("m_address", 64'(m_address), 64'(model_q[0].addr));
            checkOutput("m_writedata", 64'(m_writedata), 64'(model_q[0].data));
        end else begin
            checkOutput("m_address_idle", 64'(m_address), 64'd0);
            checkOutput("m_writedata_idle", 64'(m_writedata), 64'd0);
        end
        checkOutput("level", 64'(level), 64'(model_q.size()));
        checkOutput("err_read", 64'(err_read), 64'(model_err));
        checkOutput("s_readdata", 64'(s_readdata), 64'd0);
        checkOutput("m_read", 64'(m_read), 64'd0);
        @(posedge clk);
        exp_pop  = (model_q.size() != 0) && !mwait;
        exp_push = wr && !exp_full;
        if (exp_pop) begin
            void'(model_q.pop_front());
        end
        if (exp_push) begin
            model_q.push_back('{addr: addr, data: data});
        end
        if (rd) begin
            model_err = 1'b1;
        end
        accepted = exp_push;
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   tries;
        int   cycles;

        num_compared   = 0;
        num_mismatched = 0;
        model_err      = 1'b0;
        reset_n        = 1'b0;
        s_address      = '0;
        s_write        = 1'b1;
        s_writedata    = '0;
        s_read         = 1'b0;
        m_waitrequest  = 1'b0;

        // Reset state. s_write is held high to show that no stall occurs in reset.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_level", 64'(level), 64'd0);
        checkOutput("rst_m_write", 64'(m_write), 64'd0);
        checkOutput("rst_m_address", 64'(m_address), 64'd0);
        checkOutput("rst_m_writedata", 64'(m_writedata), 64'd0);
        checkOutput("rst_s_waitrequest", 64'(s_waitrequest), 64'd0);
        checkOutput("rst_err_read", 64'(err_read), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single write. It is pushed on the first edge after reset release.
        applyStimulus(1'b1, 32'h0800_0104, 16'h0033, 1'b0, 1'b0, acc);
        checkOutput("single_accepted", 64'(acc), 64'd1);
        checkOutput("single_level1", 64'(level), 64'd1);
        checkOutput("single_m_write", 64'(m_write), 64'd1);
        checkOutput("single_m_address", 64'(m_address), 64'h0800_0104);
        checkOutput("single_m_writedata", 64'(m_writedata), 64'h0033);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
        checkOutput("single_level0", 64'(level), 64'd0);
        checkOutput("single_m_write_off", 64'(m_write), 64'd0);
        checkOutput("single_m_address_off", 64'(m_address), 64'd0);

        // Back-pressure fill: four writes are accepted and the fifth stalls.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000_0100 + 32'(i), 16'h0040 + 16'(i), 1'b0, 1'b1, acc);
            checkOutput("fill_accepted", 64'(acc), 64'd1);
        end
        checkOutput("fill_level4", 64'(level), 64'd4);
        applyStimulus(1'b1, 32'h0000_0104, 16'h0044, 1'b0, 1'b1, acc);
        checkOutput("fill_fifth_stalled", 64'(acc), 64'd0);
        checkOutput("fill_head_stable", 64'(m_address), 64'h0000_0100);
        // The release cycle pops the head. The fifth write is still stalled because
        // the count is full.
        applyStimulus(1'b1, 32'h0000_0104, 16'h0044, 1'b0, 1'b0, acc);
        checkOutput("fill_stall_on_pop", 64'(acc), 64'd0);
        checkOutput("fill_level3", 64'(level), 64'd3);
        applyStimulus(1'b1, 32'h0000_0104, 16'h0044, 1'b0, 1'b0, acc);
        checkOutput("fill_fifth_accepted", 64'(acc), 64'd1);
        checkOutput("fill_level3_again", 64'(level), 64'd3);
        checkOutput("fill_head_third", 64'(m_address), 64'h0000_0102);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
        end
        checkOutput("fill_drained", 64'(level), 64'd0);

        // Streaming: one write per cycle in and out, and the level stays at 1.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h0800_0300 + 32'(i), 16'h0061 + 16'(i), 1'b0, 1'b0, acc);
            checkOutput("stream_accepted", 64'(acc), 64'd1);
            checkOutput("stream_level", 64'(level), 64'd1);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
        checkOutput("stream_drained", 64'(level), 64'd0);

        // Wrap-around: 3 x DEPTH writes under random back-pressure. The writer
        // holds each request until it is accepted.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 50) begin
                applyStimulus(1'b1, 32'h0800_0200 + 32'(2 * i), 16'h0041 + 16'(i), 1'b0,
                              1'($urandom_range(0, 1)), acc);
                tries++;
            end
            if (!acc) begin
                checkOutput("wrap_accept_timeout", 64'd0, 64'd1);
            end
        end
        cycles = 0;
        while (model_q.size() != 0 && cycles < 100) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), acc);
            cycles++;
        end
        checkOutput("wrap_drained", 64'(level), 64'd0);

        // Read error with two entries held.
        applyStimulus(1'b1, 32'h0000_0500, 16'h0051, 1'b0, 1'b1, acc);
        applyStimulus(1'b1, 32'h0000_0501, 16'h0052, 1'b0, 1'b1, acc);
        checkOutput("rd_level2", 64'(level), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, acc);
        checkOutput("rd_err_set", 64'(err_read), 64'd1);
        checkOutput("rd_level_kept", 64'(level), 64'd2);
        checkOutput("rd_head_kept", 64'(m_address), 64'h0000_0500);
        // A simultaneous write and read: the write is still taken.
        applyStimulus(1'b1, 32'h0000_0502, 16'h0053, 1'b1, 1'b1, acc);
        checkOutput("rdwr_accepted", 64'(acc), 64'd1);
        checkOutput("rdwr_level3", 64'(level), 64'd3);
        checkOutput("rdwr_err", 64'(err_read), 64'd1);

        // Reset mid-operation: three entries are queued and the head is stalled.
        s_write = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_m_write", 64'(m_write), 64'd0);
        checkOutput("midrst_level", 64'(level), 64'd0);
        checkOutput("midrst_err", 64'(err_read), 64'd0);
        checkOutput("midrst_m_address", 64'(m_address), 64'd0);
        checkOutput("midrst_s_waitrequest", 64'(s_waitrequest), 64'd0);
        model_q.delete();
        model_err = 1'b0;
        s_write   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        // No queued entry may reappear after reset.
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
        checkOutput("postrst_no_reissue", 64'(m_write), 64'd0);
        applyStimulus(1'b1, 32'h0800_0777, 16'h007A, 1'b0, 1'b0, acc);
        checkOutput("postrst_head", 64'(m_address), 64'h0800_0777);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, acc);
        checkOutput("postrst_level0", 64'(level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

    // Global watchdog, so that the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule

// File: doc/vga_char_write_queue.md
VGA_CHAR_WRITE_QUEUE -- requirements
Module: vga_char_write_queue

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entry count; power of two, range 2..16.
REQ-002 Parameter: ADDR_W, default 32, Avalon address width on both ports.
REQ-003 Parameter: DATA_W, default 16, Avalon writedata width on both ports.
REQ-004 Port: clk  in  1  single clock for all state.
REQ-005 Port: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: s_address  in  ADDR_W  slave command address (char buffer address from the upstream writer).
REQ-007 Port: s_write  in  1  slave write request.
REQ-008 Port: s_writedata  in  DATA_W  slave write data (ASCII character code in bits [7:0]).
REQ-009 Port: s_read  in  1  slave read request; reads are not supported.
REQ-010 Port: s_readdata  out  DATA_W  always 0.
REQ-011 Port: s_waitrequest  out  1  stall to the upstream writer; combinational.
REQ-012 Port: m_address  out  ADDR_W  master address to the VGA char buffer.
REQ-013 Port: m_write  out  1  master write strobe.
REQ-014 Port: m_writedata  out  DATA_W  master write data.
REQ-015 Port: m_read  out  1  tied 0.
REQ-016 Port: m_waitrequest  in  1  stall from the VGA char buffer.
REQ-017 Port: level  out  $clog2(DEPTH)+1  current occupied-entry count.
REQ-018 Port: err_read  out  1  sticky flag, set by any slave read attempt.

Function
REQ-019 Storage: DEPTH-entry FIFO of {address, data} pairs; read pointer, write pointer and count held in registers; pointers wrap modulo DEPTH.
REQ-020 s_waitrequest = (count == DEPTH) & s_write; the port never stalls when the FIFO is not full, or on reads.
REQ-021 Push: s_write & ~s_waitrequest writes {s_address, s_writedata} at the write pointer on that clock edge.
REQ-022 Master side is show-ahead: m_write = (count != 0); m_address and m_writedata present the head entry whenever m_write = 1, and are 0 otherwise.
REQ-023 Pop: m_write & ~m_waitrequest advances the read pointer on that clock edge.
REQ-024 While m_waitrequest = 1, m_address, m_writedata and m_write hold stable.
REQ-025 Latency: a push into an empty FIFO appears on m_write on the next cycle; there is no same-cycle bypass.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
REQ-027 Full (count == DEPTH) with a pop in the same cycle: the push is stalled, because s_waitrequest is computed from count only; the push is accepted on the next cycle.
REQ-028 Empty: no pop is possible; m_write = 0.
REQ-029 Ordering: entries issue on the master port in exactly acceptance order, with no coalescing or dropping.
REQ-030 Reads: when s_read = 1, s_readdata = 0 in the same cycle, no stall, err_read sets on the next edge, and FIFO state is unaffected.
REQ-031 s_write and s_read asserted together: the write is processed per REQ-020/021 and err_read is still set.
REQ-032 level = count, registered; count stays within 0..DEPTH under all stimulus.

Reset
REQ-033 Asynchronous reset (reset_n = 0) clears pointers, count, level and err_read to 0; m_write = 0, m_address = 0, m_writedata = 0, s_waitrequest = 0 while in reset.
REQ-034 Reset mid-transfer discards all queued entries, including a head entry stalled by m_waitrequest; no partial write is reissued after reset.
REQ-035 Storage array contents need no reset; they are unobservable while count = 0.
REQ-036 Reset deassertion is used synchronously to clk; the first push is accepted on the first edge after reset_n rises.

Verification
REQ-037 Single write: reset; push {0x08000104, 0x0033} with m_waitrequest = 0 -> m_write = 1 with the same values exactly one cycle later for one cycle; level goes 0->1->0.
REQ-038 Back-pressure fill: hold m_waitrequest = 1; push 5 writes with DEPTH = 4 -> level = 4, s_waitrequest = 1 on the 5th; release -> the 5 entries issue in order, 5th accepted the cycle after the first pop.
REQ-039 Streaming: continuous pushes and m_waitrequest = 0 -> one write per cycle on m_*, level constant at 1, no stalls.
REQ-040 Wrap-around: 3 x DEPTH writes with random m_waitrequest -> output sequence identical to input sequence.
REQ-041 Read error: s_read pulse while level = 2 -> s_readdata = 0, no stall, err_read = 1 thereafter, level still 2.
REQ-042 Reset mid-operation: level = 3 and head stalled; pulse reset_n low asynchronously between edges -> m_write drops immediately, level = 0, err_read = 0.
